// File: rtl/div_csr_pkg.sv
// rtl/div_csr_pkg.sv - shared register map, STATUS bit positions and FSM states for div_csr_ctrl
package div_csr_pkg;

   // Byte offsets within the writable window (BASE_IN)
   localparam logic [31:0] OFF_DIVIDEND  = 32'h0;
   localparam logic [31:0] OFF_DIVISOR   = 32'h4;

   // Byte offsets within the read-only window (BASE_OUT)
   localparam logic [31:0] OFF_QUOTIENT  = 32'h0;
   localparam logic [31:0] OFF_REMAINDER = 32'h4;
   localparam logic [31:0] OFF_STATUS    = 32'h8;

   // STATUS register bit positions
   localparam int STATUS_BUSY_BIT  = 0;
   localparam int STATUS_DZ_BIT    = 1;
   localparam int STATUS_VALID_BIT = 2;

   // Number of restoring iterations, one quotient bit each
   localparam int DIV_STEPS = 32;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_CALC = 1'b1
   } div_state_e;

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative unsigned restoring radix-2 divider, one quotient bit per cycle
module div_iter
   import div_csr_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic        active;
   logic [4:0]  cnt;
   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dsr_q;

   logic [32:0] trial;
   logic        ge;
   logic [31:0] diff;
   logic [31:0] rem_nxt;
   logic [31:0] quo_nxt;
   logic        dz;

   // One restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
   // quo_q starts as the dividend and is shifted left as quotient bits enter at the bottom.
   always_comb begin
      trial   = {rem_q, quo_q[31]};
      ge      = (trial >= {1'b0, dsr_q});
      diff    = trial[31:0] - dsr_q;
      rem_nxt = ge ? diff : trial[31:0];
      quo_nxt = {quo_q[30:0], ge};
      dz      = (dsr_q == 32'd0);
   end

   // Divide-by-zero finishes on its first cycle; otherwise the last step is the one at count 31.
   // Results are presented combinationally on the done cycle so the caller can capture them.
   always_comb begin
      done      = active && (dz || (cnt == 5'(DIV_STEPS - 1)));
      quotient  = dz ? 32'hFFFF_FFFF : quo_nxt;
      remainder = dz ? quo_q : rem_nxt;
   end

   // Iteration state: load operands on start, step until done, then go quiet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= 1'b0;
         cnt    <= 5'd0;
         rem_q  <= 32'd0;
         quo_q  <= 32'd0;
         dsr_q  <= 32'd0;
      end else if (start) begin
         active <= 1'b1;
         cnt    <= 5'd0;
         rem_q  <= 32'd0;
         quo_q  <= dividend;
         dsr_q  <= divisor;
      end else if (active) begin
         if (done) begin
            active <= 1'b0;
         end else begin
            cnt   <= cnt + 5'd1;
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
         end
      end
   end

endmodule

// File: rtl/div_csr_ctrl.sv
// rtl/div_csr_ctrl.sv - register-mapped front end for the iterative divider: decode, registers, sequencing
module div_csr_ctrl
   import div_csr_pkg::*;
#(
   parameter logic [31:0] DIVISOR_INIT = 32'd10,
   parameter logic [31:0] BASE_IN      = 32'h1000_0000,
   parameter logic [31:0] BASE_OUT     = 32'h2000_0000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        host_req_i,
   input  logic        host_we_i,
   input  logic [31:0] host_addr_bi,
   input  logic [31:0] host_wdata_bi,
   output logic        host_ack_o,
   output logic        host_resp_o,
   output logic [31:0] host_rdata_bo,
   output logic        busy_o
);

   div_state_e  state;
   logic [31:0] divisor_reg;
   logic [31:0] quotient_reg;
   logic [31:0] remainder_reg;
   logic        dz_flag;
   logic        valid_flag;

   logic        sel_dividend;
   logic        sel_divisor;
   logic        sel_quotient;
   logic        sel_remainder;
   logic        sel_status;
   logic        calc;
   logic        stall;
   logic        launch;
   logic        wr_divisor;
   logic        rd_accept;
   logic [31:0] status_word;
   logic [31:0] rd_mux;

   logic        iter_done;
   logic [31:0] iter_quotient;
   logic [31:0] iter_remainder;

   // Address decode and stall policy: only a new launch or a result read has to wait for IDLE.
   always_comb begin
      sel_dividend  = (host_addr_bi == BASE_IN  + OFF_DIVIDEND);
      sel_divisor   = (host_addr_bi == BASE_IN  + OFF_DIVISOR);
      sel_quotient  = (host_addr_bi == BASE_OUT + OFF_QUOTIENT);
      sel_remainder = (host_addr_bi == BASE_OUT + OFF_REMAINDER);
      sel_status    = (host_addr_bi == BASE_OUT + OFF_STATUS);
      calc          = (state == ST_CALC);
      stall         = calc && ((host_we_i && sel_dividend) ||
                               (!host_we_i && (sel_quotient || sel_remainder)));
      host_ack_o    = rst_n_i && host_req_i && !stall;
      launch        = host_ack_o && host_we_i && sel_dividend;
      wr_divisor    = host_ack_o && host_we_i && sel_divisor;
      rd_accept     = host_ack_o && !host_we_i;
   end

   // STATUS assembly and read-data selection; unmapped and write-only addresses read as zero.
   always_comb begin
      status_word                   = 32'd0;
      status_word[STATUS_BUSY_BIT]  = calc;
      status_word[STATUS_DZ_BIT]    = dz_flag;
      status_word[STATUS_VALID_BIT] = valid_flag;
      rd_mux = 32'd0;
      if (sel_divisor)   rd_mux = divisor_reg;
      if (sel_quotient)  rd_mux = quotient_reg;
      if (sel_remainder) rd_mux = remainder_reg;
      if (sel_status)    rd_mux = status_word;
   end

   div_iter u_div_iter (
      .clk       (clk_i),
      .rst_n     (rst_n_i),
      .start     (launch),
      .dividend  (host_wdata_bi),
      .divisor   (divisor_reg),
      .done      (iter_done),
      .quotient  (iter_quotient),
      .remainder (iter_remainder)
   );

   // FSM and result registers: launch samples the divisor, completion publishes the result.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state         <= ST_IDLE;
         quotient_reg  <= 32'd0;
         remainder_reg <= 32'd0;
         dz_flag       <= 1'b0;
         valid_flag    <= 1'b0;
         busy_o        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (launch) begin
                  state      <= ST_CALC;
                  busy_o     <= 1'b1;
                  valid_flag <= 1'b0;
                  dz_flag    <= (divisor_reg == 32'd0);
               end
            end
            ST_CALC: begin
               if (iter_done) begin
                  state         <= ST_IDLE;
                  busy_o        <= 1'b0;
                  quotient_reg  <= iter_quotient;
                  remainder_reg <= iter_remainder;
                  valid_flag    <= 1'b1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

   // DIVISOR register: writable at any time, the running division keeps its own copy.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         divisor_reg <= DIVISOR_INIT;
      end else if (wr_divisor) begin
         divisor_reg <= host_wdata_bi;
      end
   end

   // Read response: data and valid strobe appear exactly one cycle after the accepted read.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         host_resp_o   <= 1'b0;
         host_rdata_bo <= 32'd0;
      end else begin
         host_resp_o   <= rd_accept;
         host_rdata_bo <= rd_accept ? rd_mux : 32'd0;
      end
   end

endmodule

// File: tb/tb_div_csr_ctrl.sv
// tb/tb_div_csr_ctrl.sv - self-checking bench for div_csr_ctrl: vector table, scoreboard, corner sequences
module tb_div_csr_ctrl;

   localparam logic [31:0] BI = 32'h1000_0000;
   localparam logic [31:0] BO = 32'h2000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        ack;
   logic        resp;
   logic [31:0] rdata;
   logic        busy;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   typedef struct {
      logic [31:0] dividend;
      logic [31:0] divisor;
      logic [31:0] quo;
      logic [31:0] rem;
      logic [31:0] status;
      int          busy_cycles;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   div_csr_ctrl dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .host_req_i    (req),
      .host_we_i     (we),
      .host_addr_bi  (addr),
      .host_wdata_bi (wdata),
      .host_ack_o    (ack),
      .host_resp_o   (resp),
      .host_rdata_bo (rdata),
      .busy_o        (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard side: every response must match the oldest outstanding read; no ack without req.
   always @(negedge clk) begin : monitor
      logic [31:0] e;
      string       t;
      if (rst_n) begin
         if (!req) check("ack_without_req", {31'd0, ack}, 32'd0);
         if (resp) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_resp: got resp=1 expected no response");
            end else begin
               e = exp_q.pop_front();
               t = tag_q.pop_front();
               check(t, rdata, e);
            end
         end
      end
   end

   task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input string name, output int waited);
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d;
      waited = 0;
      #1;
      while (!ack && waited < 100) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!ack) begin
         tests++;
         fails++;
         $display("FAIL %s_ack_timeout: got no ack expected ack within 100 cycles", name);
         req = 1'b0; we = 1'b0;
      end else begin
         if (!w) begin
            exp_q.push_back(exp);
            tag_q.push_back(name);
         end
         @(posedge clk);
         #1;
         req = 1'b0; we = 1'b0;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input string name);
      int w;
      bus(1'b1, a, d, 32'd0, name, w);
      check({name, "_wait"}, w, 0);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
      int w;
      bus(1'b0, a, 32'd0, exp, name, w);
      check({name, "_wait"}, w, 0);
   endtask

   task automatic measure_busy(output int n);
      n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int w;
      int n;
      logic [31:0] dd;
      logic [31:0] dv;

      vecs[0] = '{32'd900,        32'd7,          32'd128,        32'd4,          32'h4, 32};
      vecs[1] = '{32'd100,        32'd7,          32'd14,         32'd2,          32'h4, 32};
      vecs[2] = '{32'd500,        32'd0,          32'hFFFF_FFFF,  32'd500,        32'h6,  1};
      vecs[3] = '{32'd10,         32'd3,          32'd3,          32'd1,          32'h4, 32};
      vecs[4] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          32'h4, 32};
      vecs[5] = '{32'd5,          32'd9,          32'd0,          32'd5,          32'h4, 32};
      vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          32'h4, 32};
      vecs[7] = '{32'h8000_0000,  32'h8000_0001,  32'd0,          32'h8000_0000,  32'h4, 32};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_ack",   {31'd0, ack},  32'd0);
      check("rst_resp",  {31'd0, resp}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      rst_n = 1'b1;
      rd(BI + 4, 32'd10, "rst_divisor");
      rd(BO + 0, 32'd0,  "rst_quotient");
      rd(BO + 4, 32'd0,  "rst_remainder");
      rd(BO + 8, 32'd0,  "rst_status");

      // Vector table
      foreach (vecs[i]) begin
         wr(BI + 4, vecs[i].divisor, $sformatf("v%0d_wr_divisor", i));
         wr(BI + 0, vecs[i].dividend, $sformatf("v%0d_wr_dividend", i));
         measure_busy(n);
         check($sformatf("v%0d_busy_cycles", i), n, vecs[i].busy_cycles);
         rd(BO + 0, vecs[i].quo,     $sformatf("v%0d_quotient", i));
         rd(BO + 4, vecs[i].rem,     $sformatf("v%0d_remainder", i));
         rd(BO + 8, vecs[i].status,  $sformatf("v%0d_status", i));
         rd(BI + 4, vecs[i].divisor, $sformatf("v%0d_divisor", i));
      end

      // Random operands against the bench's own arithmetic
      for (int k = 0; k < 4; k++) begin
         dd = $urandom;
         dv = $urandom_range(1, 100000);
         wr(BI + 4, dv, "rnd_wr_divisor");
         wr(BI + 0, dd, "rnd_wr_dividend");
         measure_busy(n);
         check("rnd_busy_cycles", n, 32);
         rd(BO + 0, dd / dv, "rnd_quotient");
         rd(BO + 4, dd % dv, "rnd_remainder");
      end

      // Result read right after launch stalls until IDLE; STATUS and DIVISOR do not stall
      wr(BI + 4, 32'd7, "stall_wr_divisor");
      wr(BI + 0, 32'd100, "stall_wr_dividend");
      rd(BO + 8, 32'h1, "stall_status_during_calc");
      rd(BI + 4, 32'd7, "stall_divisor_during_calc");
      bus(1'b0, BO + 0, 32'd0, 32'd14, "stall_quotient", w);
      check("stall_quotient_wait", w, 30);
      rd(BO + 4, 32'd2, "stall_remainder");

      // Back-to-back launch: second DIVIDEND write waits for the first division
      wr(BI + 0, 32'd100, "b2b_first");
      bus(1'b1, BI + 0, 32'd900, 32'd0, "b2b_second", w);
      check("b2b_second_wait", w, 32);
      measure_busy(n);
      check("b2b_busy_cycles", n, 32);
      rd(BO + 0, 32'd128, "b2b_quotient");

      // Immediate stall check: quotient read issued in cycle N+1 is acked in N+33
      wr(BI + 0, 32'd100, "n33_wr_dividend");
      bus(1'b0, BO + 0, 32'd0, 32'd14, "n33_quotient", w);
      check("n33_quotient_wait", w, 32);

      // DIVISOR rewritten mid-division does not disturb the running result
      wr(BI + 0, 32'd900, "mid_wr_dividend");
      repeat (4) @(negedge clk);
      wr(BI + 4, 32'd9, "mid_wr_divisor");
      measure_busy(n);
      rd(BO + 0, 32'd128, "mid_quotient");
      rd(BO + 4, 32'd4,   "mid_remainder");
      rd(BI + 4, 32'd9,   "mid_divisor");

      // Reset during CALC aborts with no partial result
      wr(BI + 4, 32'd7, "abort_wr_divisor");
      wr(BI + 0, 32'd900, "abort_wr_dividend");
      repeat (10) @(negedge clk);
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      req = 1'b1; we = 1'b0; addr = BO + 8;
      #1;
      check("abort_busy",  {31'd0, busy}, 32'd0);
      check("abort_ack",   {31'd0, ack},  32'd0);
      check("abort_resp",  {31'd0, resp}, 32'd0);
      check("abort_rdata", rdata, 32'd0);
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rd(BI + 4, 32'd10, "abort_divisor");
      rd(BO + 0, 32'd0,  "abort_quotient");
      rd(BO + 8, 32'd0,  "abort_status");

      // Unmapped and read-only addresses
      rd(32'h3000_0000, 32'd0, "unmapped_read");
      wr(32'h3000_0000, 32'hDEAD_BEEF, "unmapped_write");
      wr(BO + 0, 32'h1234_5678, "ro_write_quotient");
      wr(BO + 8, 32'hFFFF_FFFF, "ro_write_status");
      rd(BI + 0, 32'd0, "dividend_read_zero");
      rd(BI + 4, 32'd10, "unmapped_divisor_kept");
      rd(BO + 0, 32'd0,  "unmapped_quotient_kept");
      rd(BO + 8, 32'd0,  "unmapped_status_kept");

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/div_csr_ctrl.md
DIV_CSR_CTRL -- requirements
Module: div_csr_ctrl

Interface
REQ-001 SHALL have parameter DIVISOR_INIT, default 32'd10: reset value of the DIVISOR register.
REQ-002 SHALL have parameter BASE_IN, default 32'h10000000: base address of the writable registers.
REQ-003 SHALL have parameter BASE_OUT, default 32'h20000000: base address of the read-only registers.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n_i, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port host_req_i, input, 1: bus request.
REQ-007 SHALL have port host_we_i, input, 1: write enable; 0 = read.
REQ-008 SHALL have port host_addr_bi, input, 32: byte address.
REQ-009 SHALL have port host_wdata_bi, input, 32: write data.
REQ-010 SHALL have port host_ack_o, output, 1: request accepted this cycle.
REQ-011 SHALL have port host_resp_o, output, 1: read data valid.
REQ-012 SHALL have port host_rdata_bo, output, 32: read data.
REQ-013 SHALL have port busy_o, output, 1: division in progress.

Function
REQ-014 Register map SHALL be: DIVIDEND BASE_IN+0 (W, launches division); DIVISOR BASE_IN+4 (RW); QUOTIENT BASE_OUT+0 (R); REMAINDER BASE_OUT+4 (R); STATUS BASE_OUT+8 (R; bit0 busy, bit1 div-by-zero, bit2 result valid).
REQ-015 FSM SHALL have states IDLE and CALC: IDLE->CALC on accepted DIVIDEND write; CALC->IDLE when iteration counter reaches 31.
REQ-016 Division SHALL be unsigned restoring radix-2, one quotient bit per cycle, 32 iterations.
REQ-017 DIVIDEND write accepted (ack) in cycle N SHALL give busy_o=1 in cycles N+1..N+32, results stored and busy_o=0 from cycle N+33.
REQ-018 Divisor SHALL be sampled at launch; a DIVISOR write during CALC SHALL update the register without affecting the running division.
REQ-019 DIVIDEND write during CALC SHALL be stalled (host_ack_o=0) until the FSM is in IDLE, then accepted.
REQ-020 QUOTIENT/REMAINDER reads during CALC SHALL be stalled until IDLE; STATUS and DIVISOR reads SHALL never stall.
REQ-021 Non-stalled requests SHALL be acked in the same cycle as host_req_i; a read SHALL assert host_resp_o with data exactly one cycle after its ack.
REQ-022 Divisor 0 SHALL skip iteration, complete in 1 cycle (busy_o high for one cycle), give QUOTIENT=32'hFFFFFFFF, REMAINDER=dividend and set STATUS.bit1; any nonzero launch clears bit1.
REQ-023 STATUS.bit2 SHALL clear at launch and set on completion.
REQ-024 Writes to unmapped or read-only addresses SHALL be acked and ignored; reads of unmapped addresses SHALL return 0.
REQ-025 host_resp_o SHALL never be asserted without a prior accepted read; host_ack_o SHALL never be asserted while host_req_i=0.

Reset
REQ-026 On rst_n_i=0, asynchronously: FSM=IDLE, counter=0, QUOTIENT=REMAINDER=0, DIVISOR=DIVISOR_INIT, STATUS=0, host_ack_o=host_resp_o=busy_o=0, host_rdata_bo=0.
REQ-027 Reset during CALC SHALL abort the division; no partial result SHALL become visible.

Structure
REQ-028 Register offsets, STATUS bit indices and the FSM state enum SHALL be in shared package div_csr_pkg.
REQ-029 The iterative datapath (shift/subtract, counter, start/done) SHALL be sub-module div_iter; div_csr_ctrl SHALL hold bus decode, registers and sequencing.

Verification
REQ-030 Write DIVISOR=7, DIVIDEND=900 -> after 33 cycles QUOTIENT=128, REMAINDER=4, STATUS=32'h4.
REQ-031 Write DIVIDEND=100 then read QUOTIENT immediately -> ack withheld until cycle N+33; then QUOTIENT read returns 14 and REMAINDER read returns 2.
REQ-032 DIVISOR=0, DIVIDEND=500 -> QUOTIENT=32'hFFFFFFFF, REMAINDER=500, STATUS=32'h6; next launch with DIVISOR=3, DIVIDEND=10 -> 3 r 1, STATUS=32'h4.
REQ-033 Launch 900/7, write DIVISOR=9 at N+5 -> result still 128 r 4; DIVISOR reads 9.
REQ-034 Assert rst_n_i at N+10 of a division -> all outputs 0 immediately; DIVISOR=10; QUOTIENT reads 0 after release.
REQ-035 Read 32'h30000000 -> ack same cycle, resp next cycle, data 0; write there -> no register changes.
